multi_shift_reg: RTL and testbench

MULTI_SHIFT_REG -- requirements
Module: multi_shift_reg

---
 rtl/multi_shift_reg_pkg.sv | 19 +
 rtl/multi_shift_reg_shift_step.sv | 40 ++++
 rtl/multi_shift_reg.sv | 110 +++++++++++
 tb/tb_multi_shift_reg.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/multi_shift_reg_pkg.sv
// Shared encodings for the multi-bit shift register: shift modes and FSM states.
package multi_shift_reg_pkg;

  localparam int unsigned MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_LOGIC = 2'b00;
  localparam logic [MODE_W-1:0] MODE_ROT   = 2'b01;
  localparam logic [MODE_W-1:0] MODE_ARITH = 2'b10;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/multi_shift_reg_shift_step.sv
// Combinational single-bit shift: computes the shifted word and the departing bit.
module shift_step
  import multi_shift_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0]  data,
  input  logic              dir,
  input  logic [MODE_W-1:0] mode,
  input  logic              ser_in,
  output logic [WIDTH-1:0]  next_data,
  output logic              out_bit
);

  logic fill;

  always_comb begin
    fill      = ser_in;
    next_data = data;
    out_bit   = 1'b0;
    if (dir == DIR_LEFT) begin
      out_bit = data[WIDTH-1];
      case (mode)
        MODE_ROT:   fill = data[WIDTH-1];
        MODE_ARITH: fill = 1'b0;
        default:    fill = ser_in;
      endcase
      next_data = {data[WIDTH-2:0], fill};
    end else begin
      out_bit = data[0];
      case (mode)
        MODE_ROT:   fill = data[0];
        MODE_ARITH: fill = data[WIDTH-1];
        default:    fill = ser_in;
      endcase
      next_data = {fill, data[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/multi_shift_reg.sv
// Loadable shift register that performs a programmable number of single-bit
// logical/rotate/arithmetic shifts, one per clock, under a small Moore FSM.
module multi_shift_reg
  import multi_shift_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [WIDTH-1:0]  i_data,
  input  logic              i_start,
  input  logic              i_dir,
  input  logic [1:0]        i_mode,
  input  logic [CNT_W-1:0]  i_amount,
  input  logic              i_ser_in,
  output logic [WIDTH-1:0]  o_out,
  output logic              o_ser_out,
  output logic              o_busy,
  output logic              o_done
);

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                dir_q, dir_d;
  logic [MODE_W-1:0]   mode_q, mode_d;
  logic                ser_q, ser_d;
  logic                busy_q, done_q;
  logic [WIDTH-1:0]    step_data;
  logic                step_bit;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .data      (data_q),
    .dir       (dir_q),
    .mode      (mode_q),
    .ser_in    (i_ser_in),
    .next_data (step_data),
    .out_bit   (step_bit)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      mode_q  <= '0;
      ser_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      ser_q   <= ser_d;
      // Status flags track the state register exactly, one flop each.
      busy_q  <= (state_d == ST_SHIFT);
      done_q  <= (state_d == ST_DONE);
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    ser_d   = ser_q;
    case (state_q)
      ST_IDLE: begin
        if (i_load) begin
          data_d = i_data;
        end else if (i_start) begin
          if (i_amount == '0) begin
            state_d = ST_DONE;
          end else begin
            dir_d   = i_dir;
            mode_d  = i_mode;
            cnt_d   = i_amount;
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        data_d = step_data;
        ser_d  = step_bit;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign o_out     = data_q;
  assign o_ser_out = ser_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;

endmodule

// File: tb/tb_multi_shift_reg.sv
// Directed, table-driven bench for multi_shift_reg with hand-computed results.
module tb_multi_shift_reg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CNT_W = 5;

  logic              i_clk;
  logic              i_rst_n;
  logic              i_load;
  logic [WIDTH-1:0]  i_data;
  logic              i_start;
  logic              i_dir;
  logic [1:0]        i_mode;
  logic [CNT_W-1:0]  i_amount;
  logic              i_ser_in;
  logic [WIDTH-1:0]  o_out;
  logic              o_ser_out;
  logic              o_busy;
  logic              o_done;

  int n_vec;
  int n_err;

  typedef struct {
    logic [15:0] data;
    logic        dir;
    logic [1:0]  mode;
    logic [4:0]  amount;
    logic        ser_in;
    logic [15:0] exp_out;
    logic        exp_ser;
  } vec_t;

  vec_t vecs[9];

  multi_shift_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_load    (i_load),
    .i_data    (i_data),
    .i_start   (i_start),
    .i_dir     (i_dir),
    .i_mode    (i_mode),
    .i_amount  (i_amount),
    .i_ser_in  (i_ser_in),
    .o_out     (o_out),
    .o_ser_out (o_ser_out),
    .o_busy    (o_busy),
    .o_done    (o_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] d);
    i_load = 1'b1;
    i_data = d;
    tick();
    i_load = 1'b0;
    check("load", 32'(o_out), 32'(d));
  endtask

  // Starts an operation and measures the busy window; leaves time in the done cycle.
  task automatic do_start(input logic dir, input logic [1:0] mode, input logic [4:0] amt,
                          input logic ser, output int busy_cycles);
    i_start  = 1'b1;
    i_dir    = dir;
    i_mode   = mode;
    i_amount = amt;
    i_ser_in = ser;
    tick();
    i_start = 1'b0;
    busy_cycles = 0;
    while (o_busy === 1'b1 && busy_cycles < 100) begin
      busy_cycles++;
      tick();
    end
  endtask

  int bc;

  initial begin
    n_vec = 0; n_err = 0;
    i_rst_n = 1'b0; i_load = 1'b0; i_data = '0; i_start = 1'b0;
    i_dir = 1'b0; i_mode = 2'b00; i_amount = '0; i_ser_in = 1'b0;

    vecs[0] = '{16'h8888, 1'b0, 2'b00, 5'd1,  1'b0, 16'h1110, 1'b1};
    vecs[1] = '{16'h1234, 1'b1, 2'b01, 5'd4,  1'b0, 16'h4123, 1'b0};
    vecs[2] = '{16'h8888, 1'b1, 2'b10, 5'd3,  1'b0, 16'hF111, 1'b0};
    vecs[3] = '{16'h8888, 1'b0, 2'b10, 5'd3,  1'b1, 16'h4440, 1'b0};
    vecs[4] = '{16'h8001, 1'b0, 2'b01, 5'd1,  1'b0, 16'h0003, 1'b1};
    vecs[5] = '{16'h0001, 1'b1, 2'b00, 5'd2,  1'b1, 16'hC000, 1'b0};
    vecs[6] = '{16'h00FF, 1'b0, 2'b11, 5'd4,  1'b1, 16'h0FFF, 1'b0};
    vecs[7] = '{16'hA5A5, 1'b0, 2'b01, 5'd20, 1'b0, 16'h5A5A, 1'b0};
    vecs[8] = '{16'hFFFF, 1'b0, 2'b00, 5'd17, 1'b0, 16'h0000, 1'b0};

    // Reset state
    repeat (3) @(posedge i_clk);
    #2 i_rst_n = 1'b1;
    tick();
    check("rst_out",  32'(o_out), 32'h0);
    check("rst_busy", 32'(o_busy), 32'h0);
    check("rst_done", 32'(o_done), 32'h0);
    check("rst_ser",  32'(o_ser_out), 32'h0);

    for (int i = 0; i < 9; i++) begin
      do_load(vecs[i].data);
      do_start(vecs[i].dir, vecs[i].mode, vecs[i].amount, vecs[i].ser_in, bc);
      check($sformatf("v%0d_busy_cycles", i), 32'(bc), 32'(vecs[i].amount));
      check($sformatf("v%0d_done", i), 32'(o_done), 32'h1);
      check($sformatf("v%0d_out", i), 32'(o_out), 32'(vecs[i].exp_out));
      check($sformatf("v%0d_ser", i), 32'(o_ser_out), 32'(vecs[i].exp_ser));
      tick();
      check($sformatf("v%0d_done_drop", i), 32'(o_done), 32'h0);
    end

    // Zero amount: straight to DONE, data untouched
    do_load(16'hBEEF);
    do_start(1'b0, 2'b00, 5'd0, 1'b1, bc);
    check("amt0_busy", 32'(bc), 32'h0);
    check("amt0_done", 32'(o_done), 32'h1);
    check("amt0_out",  32'(o_out), 32'hBEEF);
    tick();
    check("amt0_done_drop", 32'(o_done), 32'h0);

    // Load and start together: load wins
    i_load = 1'b1; i_data = 16'h00FF; i_start = 1'b1; i_amount = 5'd3;
    tick();
    i_load = 1'b0; i_start = 1'b0;
    check("ldst_out",  32'(o_out), 32'h00FF);
    check("ldst_busy", 32'(o_busy), 32'h0);
    tick();
    check("ldst_done", 32'(o_done), 32'h0);

    // Load and start issued while busy are ignored
    do_load(16'h1234);
    i_start = 1'b1; i_dir = 1'b1; i_mode = 2'b01; i_amount = 5'd4;
    tick();
    i_amount = 5'd1;
    i_load = 1'b1; i_data = 16'hFFFF;
    check("busy_hold_busy", 32'(o_busy), 32'h1);
    bc = 0;
    while (o_busy === 1'b1 && bc < 100) begin
      bc++;
      tick();
    end
    i_load = 1'b0; i_start = 1'b0;
    check("busy_hold_cycles", 32'(bc), 32'd4);
    check("busy_hold_out", 32'(o_out), 32'h4123);
    check("busy_hold_done", 32'(o_done), 32'h1);
    tick();

    // Reset during the third busy cycle aborts with no done pulse
    do_load(16'h8888);
    i_start = 1'b1; i_dir = 1'b0; i_mode = 2'b00; i_amount = 5'd8; i_ser_in = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    tick();
    check("abort_busy_before", 32'(o_busy), 32'h1);
    #1 i_rst_n = 1'b0;
    #1;
    check("abort_out",  32'(o_out), 32'h0);
    check("abort_busy", 32'(o_busy), 32'h0);
    check("abort_done", 32'(o_done), 32'h0);
    check("abort_ser",  32'(o_ser_out), 32'h0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    begin
      int saw_done;
      saw_done = 0;
      for (int k = 0; k < 10; k++) begin
        tick();
        if (o_done === 1'b1 || o_busy === 1'b1) saw_done = 1;
      end
      check("abort_no_done", 32'(saw_done), 32'h0);
    end
    do_load(16'h00AA);
    check("post_abort_busy", 32'(o_busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
